pixel_compositor: RTL and testbench

Final video stage between the sprite/tile renderers (tables, counters, chefs, items) and the VGA pins. Takes one 12-bit pixel per layer each clock, picks the highest-priority non-transparent layer, falls back to a background colour, and forces black during blanking. Sync, blank and counts are delayed so they stay aligned with the composited pixel. Also emits a per-frame tick and frame counter for game logic.

---
 rtl/overcooked_video_pkg.sv | 41 ++++
 rtl/sync_delay_line.sv | 34 +++
 rtl/pixel_compositor.sv | 161 ++++++++++++++++
 tb/tb_pixel_compositor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overcooked_video_pkg.sv
// Shared video types and constants for the Overcooked display pipeline.
package overcooked_video_pkg;

  localparam int unsigned PIXEL_W        = 12;
  localparam int unsigned HCOUNT_W       = 10;
  localparam int unsigned VCOUNT_W       = 9;
  localparam int unsigned GRID_MASK_BITS = 5;

  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam pixel_t TRANSPARENT_COLOR = 12'h000;
  localparam pixel_t GRID_COLOR        = 12'hFFF;
  localparam pixel_t BLACK_COLOR       = 12'h000;

  // Timing side-band that travels alongside the layer pixels.
  typedef struct packed {
    logic                hsync;
    logic                vsync;
    logic                blank;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
  } timing_t;

  localparam int unsigned TIMING_W = $bits(timing_t);

  // Idle timing: syncs inactive (high), blanked, counts at origin.
  localparam timing_t TIMING_IDLE = '{
    hsync:  1'b1,
    vsync:  1'b1,
    blank:  1'b1,
    hcount: '0,
    vcount: '0
  };

  // True on the 32-pixel placement grid lines.
  function automatic logic on_grid(input logic [HCOUNT_W-1:0] h,
                                   input logic [VCOUNT_W-1:0] v);
    return (h[GRID_MASK_BITS-1:0] == '0) || (v[GRID_MASK_BITS-1:0] == '0);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low reset; DEPTH 0 is a wire.
module sync_delay_line #(
  parameter int unsigned       DEPTH     = 2,
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n, RESET_VAL};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pixel_compositor.sv
// Layer priority compositor with blanking, aligned syncs and frame tick/counter.
// Optional COMPOSITOR_GRID_EN overlays a white 32-pixel placement grid.
module pixel_compositor
  import overcooked_video_pkg::*;
#(
  parameter int unsigned NUM_LAYERS    = 4,
  parameter int unsigned LAYER_LATENCY = 2,
  parameter logic [11:0] TRANSPARENT   = TRANSPARENT_COLOR
) (
  input  logic                     pixel_clk_in,
  input  logic                     rst_n_in,
  input  logic [9:0]               hcount_in,
  input  logic [8:0]               vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     blank_in,
  input  logic [12*NUM_LAYERS-1:0] layer_pixels_in,
  input  logic [11:0]              bg_color_in,
  output logic [11:0]              pixel_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     blank_out,
  output logic                     frame_tick_out,
  output logic [7:0]               frame_count_out
);

  localparam int unsigned FILL   = LAYER_LATENCY + 1;
  localparam int unsigned FILL_W = $clog2(FILL + 1);

  timing_t timing_in_c;
  timing_t timing_dly_c;

  assign timing_in_c = '{
    hsync:  hsync_in,
    vsync:  vsync_in,
    blank:  blank_in,
    hcount: hcount_in,
    vcount: vcount_in
  };

  // Bring timing into step with the late-arriving layer pixels.
  sync_delay_line #(
    .DEPTH     (LAYER_LATENCY),
    .WIDTH     (TIMING_W),
    .RESET_VAL (TIMING_IDLE)
  ) u_align (
    .clk   (pixel_clk_in),
    .rst_n (rst_n_in),
    .din   (timing_in_c),
    .dout  (timing_dly_c)
  );

  pixel_t                s1_layer [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] s1_opaque;
  pixel_t                s1_bg;
  logic                  s1_hsync;
  logic                  s1_vsync;
  logic                  s1_blank;

  // Stage 1: capture layers, background and aligned timing.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_LAYERS; i++) s1_layer[i] <= '0;
      s1_opaque <= '0;
      s1_bg     <= '0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_blank  <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        s1_layer[i]  <= layer_pixels_in[PIXEL_W*i +: PIXEL_W];
        s1_opaque[i] <= (layer_pixels_in[PIXEL_W*i +: PIXEL_W] != TRANSPARENT);
      end
      s1_bg    <= bg_color_in;
      s1_hsync <= timing_dly_c.hsync;
      s1_vsync <= timing_dly_c.vsync;
      s1_blank <= timing_dly_c.blank;
    end
  end

  logic grid_hit_c;

`ifdef COMPOSITOR_GRID_EN
  logic [HCOUNT_W-1:0] s1_hcount;
  logic [VCOUNT_W-1:0] s1_vcount;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_hcount <= '0;
      s1_vcount <= '0;
    end else begin
      s1_hcount <= timing_dly_c.hcount;
      s1_vcount <= timing_dly_c.vcount;
    end
  end

  assign grid_hit_c = on_grid(s1_hcount, s1_vcount);
`else
  logic unused_counts;
  assign unused_counts = ^{timing_dly_c.hcount, timing_dly_c.vcount};
  assign grid_hit_c    = 1'b0;
`endif

  pixel_t pix_next_c;
  logic   hit_c;

  // Lowest-index opaque layer wins; grid, then blanking, override.
  always_comb begin
    pix_next_c = s1_bg;
    hit_c      = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!hit_c && s1_opaque[i]) begin
        pix_next_c = s1_layer[i];
        hit_c      = 1'b1;
      end
    end
    if (grid_hit_c) pix_next_c = GRID_COLOR;
    if (s1_blank)   pix_next_c = BLACK_COLOR;
  end

  // Stage 2: output registers.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out <= BLACK_COLOR;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      pixel_out <= pix_next_c;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
    end
  end

  logic [FILL_W-1:0] fill_cnt;
  logic              fill_done_c;
  logic              armed;

  assign fill_done_c = (fill_cnt == FILL_W'(FILL));

  // Ticks only once a genuine high vsync has reached stage 1, so reset
  // fill values never fake a falling edge.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_cnt        <= '0;
      armed           <= 1'b0;
      frame_tick_out  <= 1'b0;
      frame_count_out <= '0;
    end else begin
      if (!fill_done_c) fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_done_c && s1_vsync) armed <= 1'b1;
      frame_tick_out <= 1'b0;
      if (armed && vsync_out && !s1_vsync) begin
        frame_tick_out  <= 1'b1;
        frame_count_out <= frame_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: latency-2 and latency-0 instances
// compared against a history-based reference model plus directed vectors.
module tb_pixel_compositor;

  localparam int LAT = 2;

`ifdef COMPOSITOR_GRID_EN
  localparam bit          GRID_ON  = 1'b1;
  localparam logic [11:0] GRID_EXP = 12'hFFF;
`else
  localparam bit          GRID_ON  = 1'b0;
  localparam logic [11:0] GRID_EXP = 12'hF00;
`endif

  typedef struct packed {
    logic [47:0] layers;
    logic [11:0] bg;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  hc;
    logic [8:0]  vc;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [11:0] exp_pix;
  } tvec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount;
  logic [8:0]  vcount;
  logic        hsync, vsync, blank;
  logic [47:0] layers;
  logic [11:0] bg;

  logic [11:0] pix_a, pix_b;
  logic        hs_a, vs_a, bl_a, tk_a, hs_b, vs_b, bl_b, tk_b;
  logic [7:0]  cnt_a, cnt_b;

  always #5 clk = ~clk;

  pixel_compositor #(.NUM_LAYERS(4), .LAYER_LATENCY(LAT), .TRANSPARENT(12'h000)) dut_a (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .layer_pixels_in(layers),
    .bg_color_in(bg), .pixel_out(pix_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .blank_out(bl_a), .frame_tick_out(tk_a), .frame_count_out(cnt_a)
  );

  pixel_compositor #(.NUM_LAYERS(4), .LAYER_LATENCY(0), .TRANSPARENT(12'h000)) dut_b (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .layer_pixels_in(layers),
    .bg_color_in(bg), .pixel_out(pix_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .blank_out(bl_b), .frame_tick_out(tk_b), .frame_count_out(cnt_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t hist[$];
  int   mcnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [11:0] l0, l1, l2, l3, b,
                               input logic bl, input logic [9:0] h, input logic [8:0] v);
    vec_t r;
    r.layers = {l3, l2, l1, l0};
    r.bg     = b;
    r.hs     = 1'b1;
    r.vs     = 1'b1;
    r.blank  = bl;
    r.hc     = h;
    r.vc     = v;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < 4; i++)
      v.layers[12*i +: 12] = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
    v.bg    = 12'($urandom);
    v.hs    = ($urandom_range(0, 5) != 0);
    v.vs    = ($urandom_range(0, 6) != 0);
    v.blank = ($urandom_range(0, 3) == 0);
    v.hc    = ($urandom_range(0, 2) == 0) ? {5'($urandom), 5'b0} : 10'($urandom);
    v.vc    = ($urandom_range(0, 2) == 0) ? {4'($urandom), 5'b0} : 9'($urandom);
    return v;
  endfunction

  // Reference: p supplies colours, a supplies the timing aligned with them.
  function automatic logic [11:0] model_pixel(input vec_t p, input vec_t a);
    logic [11:0] r;
    logic        found;
    r     = p.bg;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && p.layers[12*i +: 12] != 12'h000) begin
        r     = p.layers[12*i +: 12];
        found = 1'b1;
      end
    end
    if (GRID_ON && ((a.hc % 32) == 0 || (a.vc % 32) == 0)) r = 12'hFFF;
    if (a.blank) r = 12'h000;
    return r;
  endfunction

  task automatic check_dut(input int d, input int lat, input string tag,
                           input logic [11:0] pix, input logic hs, vs, bl, tk,
                           input logic [7:0] cnt);
    int n, j;
    logic [11:0] ep;
    logic ehs, evs, ebl, etk;
    n = hist.size() - 1;
    j = n - 1 - lat;
    if (j < 0) begin
      ep = 12'h000; ehs = 1'b1; evs = 1'b1; ebl = 1'b1;
    end else begin
      ep  = model_pixel(hist[n-1], hist[j]);
      ehs = hist[j].hs;
      evs = hist[j].vs;
      ebl = hist[j].blank;
    end
    etk = (j >= 1) && !hist[j].vs && hist[j-1].vs;
    if (etk) mcnt[d] = (mcnt[d] + 1) % 256;
    chk({tag, " pixel"}, 32'(pix), 32'(ep));
    chk({tag, " hsync"}, 32'(hs), 32'(ehs));
    chk({tag, " vsync"}, 32'(vs), 32'(evs));
    chk({tag, " blank"}, 32'(bl), 32'(ebl));
    chk({tag, " tick"},  32'(tk), 32'(etk));
    chk({tag, " count"}, 32'(cnt), 32'(mcnt[d]));
  endtask

  task automatic drive(input vec_t v);
    layers = v.layers;
    bg     = v.bg;
    hsync  = v.hs;
    vsync  = v.vs;
    blank  = v.blank;
    hcount = v.hc;
    vcount = v.vc;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input vec_t v);
    drive(v);
    hist.push_back(v);
    @(posedge clk);
    #1;
    check_dut(0, LAT, "L2", pix_a, hs_a, vs_a, bl_a, tk_a, cnt_a);
    check_dut(1, 0,   "L0", pix_b, hs_b, vs_b, bl_b, tk_b, cnt_b);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " L2 pixel"}, 32'(pix_a), 32'h000);
    chk({tag, " L2 hsync"}, 32'(hs_a), 32'd1);
    chk({tag, " L2 vsync"}, 32'(vs_a), 32'd1);
    chk({tag, " L2 blank"}, 32'(bl_a), 32'd1);
    chk({tag, " L2 tick"},  32'(tk_a), 32'd0);
    chk({tag, " L2 count"}, 32'(cnt_a), 32'd0);
    chk({tag, " L0 pixel"}, 32'(pix_b), 32'h000);
    chk({tag, " L0 vsync"}, 32'(vs_b), 32'd1);
    chk({tag, " L0 count"}, 32'(cnt_b), 32'd0);
  endtask

  // Asserts reset between clock edges, optionally checks it takes effect
  // without an edge, then releases on a negedge with the model cleared.
  task automatic apply_reset(input vec_t v, input bit check_now);
    drive(v);
    #3 rst_n = 1'b0;
    #1 if (check_now) check_reset_vals("async rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tvec_t tbl[9];
    vec_t  idle, q;
    int    found_a, found_b, nt;

    idle = mkv(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 10'd65, 9'd7);
    tbl[0] = '{mkv(12'h000, 12'h0F0, 12'h00F, 12'hFFF, 12'h000, 1'b0, 10'd65, 9'd7), 12'h0F0};
    tbl[1] = '{mkv(12'h000, 12'h000, 12'h000, 12'h000, 12'h123, 1'b0, 10'd65, 9'd7), 12'h123};
    tbl[2] = '{mkv(12'hF00, 12'h000, 12'h000, 12'h000, 12'h123, 1'b1, 10'd65, 9'd7), 12'h000};
    tbl[3] = '{mkv(12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h555, 1'b0, 10'd65, 9'd7), 12'hF00};
    tbl[4] = '{mkv(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 10'd65, 9'd7), 12'h000};
    tbl[5] = '{mkv(12'hF00, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 10'd64, 9'd7), GRID_EXP};
    tbl[6] = '{mkv(12'hF00, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 10'd65, 9'd7), 12'hF00};
    tbl[7] = '{mkv(12'h000, 12'h000, 12'h000, 12'h456, 12'h789, 1'b0, 10'd65, 9'd7), 12'h456};
    tbl[8] = '{mkv(12'hF00, 12'h0F0, 12'h000, 12'h000, 12'h321, 1'b1, 10'd0,  9'd0), 12'h000};

    // Power-on reset.
    rst_n = 1'b0;
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    hist.delete();
    mcnt[0] = 0;
    mcnt[1] = 0;

    // Directed vectors, each held until it fills both pipelines.
    for (int t = 0; t < 9; t++) begin
      repeat (LAT + 3) cycle(tbl[t].v);
      chk($sformatf("table[%0d] L2 pixel", t), 32'(pix_a), 32'(tbl[t].exp_pix));
      chk($sformatf("table[%0d] L0 pixel", t), 32'(pix_b), 32'(tbl[t].exp_pix));
      chk($sformatf("table[%0d] L2 blank", t), 32'(bl_a), 32'(tbl[t].v.blank));
    end

    // Single-cycle hsync pulse latency.
    q = idle;
    q.blank = 1'b0;
    repeat (6) cycle(q);
    found_a = -1;
    found_b = -1;
    for (int k = 1; k <= 10; k++) begin
      q.hs = (k == 1) ? 1'b0 : 1'b1;
      cycle(q);
      if (!hs_a && found_a < 0) found_a = k;
      if (!hs_b && found_b < 0) found_b = k;
    end
    chk("hsync latency L2", 32'(found_a), 32'd4);
    chk("hsync latency L0", 32'(found_b), 32'd2);

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) cycle(rnd_vec());

    // Asynchronous reset mid-stream with red layers.
    q = mkv(12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 1'b0, 10'd65, 9'd7);
    repeat (5) cycle(q);
    chk("pre-rst L2 pixel", 32'(pix_a), 32'hF00);
    apply_reset(q, 1'b1);

    // 257 vsync pulses: count wraps through 0 to 1.
    nt = 0;
    q = idle;
    q.blank = 1'b0;
    for (int p = 0; p < 257; p++) begin
      q.vs = 1'b1; cycle(q); if (tk_a) nt++;
      cycle(q);              if (tk_a) nt++;
      q.vs = 1'b0; cycle(q); if (tk_a) nt++;
    end
    q.vs = 1'b1;
    repeat (LAT + 4) begin
      cycle(q);
      if (tk_a) nt++;
    end
    chk("257 pulses tick count", 32'(nt), 32'd257);
    chk("257 pulses L2 frame_count", 32'(cnt_a), 32'd1);
    chk("257 pulses L0 frame_count", 32'(cnt_b), 32'd1);

    // vsync held low across reset release: first edge must be a real one.
    q.vs = 1'b0;
    apply_reset(q, 1'b0);
    nt = 0;
    repeat (8) begin
      cycle(q);
      if (tk_a || tk_b) nt++;
    end
    chk("low-at-release spurious ticks", 32'(nt), 32'd0);
    q.vs = 1'b1;
    repeat (3) cycle(q);
    q.vs = 1'b0;
    cycle(q);
    q.vs = 1'b1;
    repeat (LAT + 4) cycle(q);
    chk("low-at-release L2 frame_count", 32'(cnt_a), 32'd1);
    chk("low-at-release L0 frame_count", 32'(cnt_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
